lc3_memaccess: RTL and testbench
================================

# lc3_memaccess

Data-memory access stage of the LC-3 pipeline, sitting directly downstream of the pipeline controller. It consumes the controller's `mem_state` code, runs the variable-latency request/acknowledge handshake with data memory, and returns `complete_data` to the controller. Indirect loads and stores are handled as two phases: a pointer fetch followed by the final access through that pointer. Read results are presented on `memout` for the writeback stage.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: acknowledge watchdog limit. Used only with `LC3_MEM_TIMEOUT_EN`. Range 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_state` in 2: access code. 0 = read, 1 = indirect pointer read, 2 = write, 3 = idle.
- `M_Addr` in 16: effective address from execute.
- `M_Data` in 16: store data from execute.
- `DMem_dout` in 16: read data from memory. Valid in the cycle where `DMem_ack` is high.
- `DMem_ack` in 1: one-cycle completion strobe from memory.
- `DMem_addr` out 16: memory address.
- `DMem_din` out 16: memory write data.
- `DMem_req` out 1: request. Held high until it is acknowledged.
- `DMem_we` out 1: write enable. Qualified by `DMem_req`.
- `memout` out 16: most recent read result.
- `complete_data` out 1: one-cycle pulse when each access phase finishes.
- `mem_err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, RD_WAIT, IND_WAIT, WR_WAIT, DONE.
- **IDLE**, `mem_state` sampled at the clock edge:
  - 0 → RD_WAIT
  - 1 → IND_WAIT
  - 2 → WR_WAIT
  - 3 → stay in IDLE
- **Issue** (on the edge that leaves IDLE):
  - `DMem_addr` is loaded with `ptr` if `ind_pending` = 1, otherwise with `M_Addr`.
  - `DMem_din` is loaded with `M_Data`.
  - `DMem_req` is set to 1.
  - `DMem_we` is set to 1 for a write, 0 otherwise.
  - For codes 0 and 2, `ind_pending` is cleared.
- **Wait states** (RD_WAIT, IND_WAIT, WR_WAIT): `DMem_addr`, `DMem_din`, `DMem_we` and `DMem_req` hold stable until `DMem_ack` is sampled high. On that edge:
  - `DMem_req` and `DMem_we` clear, and the FSM moves to DONE.
  - RD_WAIT: `memout` is loaded with `DMem_dout`.
  - IND_WAIT: the internal 16-bit `ptr` is loaded with `DMem_dout` and `ind_pending` is set; `memout` is unchanged.
  - WR_WAIT: no data capture.
- **DONE**: `complete_data` = 1 for exactly this cycle; `mem_state` is ignored. The FSM then returns to IDLE. This allows the controller one cycle to advance `mem_state`, e.g. indirect load 1 → 0 and indirect store 1 → 2.
- `DMem_ack` outside the wait states is ignored.
- Changes on `mem_state`, `M_Addr` or `M_Data` during the wait states and DONE are ignored; operands are latched at issue.
- `memout` holds its value between reads and is never cleared except by reset.

## Timing
- Reset values (asynchronous, on `rst` low):
  - FSM = IDLE
  - `DMem_req` = 0, `DMem_we` = 0, `complete_data` = 0, `mem_err` = 0
  - `DMem_addr`, `DMem_din`, `memout` = 16'h0000
  - `ptr` = 0, `ind_pending` = 0
- Cycle-level sequence, with edge E0 sampling a non-idle `mem_state`:
  - `DMem_req` is high from E0.
  - With a zero-wait memory, `DMem_ack` is high in the cycle after E0 and is sampled at E1.
  - `complete_data` is high between E1 and E2; the FSM is back in IDLE at E2.
  - Minimum occupancy is therefore 3 cycles per phase, plus N cycles for each extra wait state.
- An indirect access is two back-to-back phases: at least 6 cycles from the first `mem_state` = 1 sample to the second `complete_data`.
- Reset asserted mid-access: `DMem_req` drops immediately (asynchronously), the access is abandoned and `ind_pending` is lost. No `complete_data` pulse is produced.

## Configuration
- `LC3_MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears at issue and increments each wait-state cycle without `DMem_ack`.
  - When the count reaches `TIMEOUT_CYCLES`, the next edge drops `DMem_req`/`DMem_we`, sets `mem_err` (sticky until reset), clears `ind_pending`, and goes to DONE, so `complete_data` still pulses.
  - `memout` and `ptr` are unchanged.
  - `DMem_ack` on the same edge as the timeout wins: the access completes normally.
- `LC3_MEM_TIMEOUT_EN` undefined: the FSM waits indefinitely, `mem_err` is tied to 0, and no counter logic is present.

## Test plan
- Plain load, zero-wait memory: `mem_state`=0, `M_Addr`=x3000, memory returns x1234 → `DMem_req` high for 1 cycle with addr x3000 and `DMem_we`=0; `memout`=x1234; one `complete_data` pulse 2 cycles after the sample edge.
- Store with 5-cycle ack delay: `mem_state`=2, addr x4000, data xBEEF → `DMem_req`/`DMem_we` held 6 cycles with stable addr/din; single `complete_data` pulse; `memout` unchanged.
- Indirect load: `mem_state` 1 then 0, addr x3000; mem[x3000]=x5000, mem[x5000]=xCAFE → second request addr x5000; `memout`=xCAFE; exactly two `complete_data` pulses.
- Indirect store: `mem_state` 1 then 2, `M_Data`=x00AA, mem[x3000]=x6000 → write to x6000 with x00AA; `ind_pending` cleared afterwards.
- Timeout (macro on, `TIMEOUT_CYCLES`=4, ack never arrives): `DMem_req` drops after 4 wait cycles; `mem_err`=1 and stays 1; one `complete_data` pulse. Macro off: `DMem_req` still high after 300 cycles.
- Robustness: a stray `DMem_ack` in IDLE → no output change. `rst` low in the middle of RD_WAIT → all outputs at their reset values within the same cycle, and the next access operates normally.

Source files
------------

// File: rtl/lc3_memaccess_if.sv
//==============================================================================
// Module   : lc3_memaccess_if
// Desc     : Data-memory request/acknowledge bus between the LC-3 memory
//            access stage (master) and data memory (slave).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface lc3_memaccess_if;
    logic [15:0] DMem_addr;
    logic [15:0] DMem_din;
    logic        DMem_req;
    logic        DMem_we;
    logic [15:0] DMem_dout;
    logic        DMem_ack;

    modport master (
        output DMem_addr,
        output DMem_din,
        output DMem_req,
        output DMem_we,
        input  DMem_dout,
        input  DMem_ack
    );

    modport slave (
        input  DMem_addr,
        input  DMem_din,
        input  DMem_req,
        input  DMem_we,
        output DMem_dout,
        output DMem_ack
    );
endinterface

`default_nettype wire

// File: rtl/lc3_memaccess.sv
//==============================================================================
// Module   : lc3_memaccess
// Desc     : LC-3 data-memory access stage: request/ack handshake, two-phase
//            indirect access, read result capture. Optional ack watchdog is
//            enabled by defining LC3_MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module lc3_memaccess #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mem_state,
    input  logic [15:0]           M_Addr,
    input  logic [15:0]           M_Data,
    lc3_memaccess_if.master       dmem,
    output logic [15:0]           memout,
    output logic                  complete_data,
    output logic                  mem_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        IND_WAIT = 3'd2,
        WR_WAIT  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [1:0] c_CODE_READ  = 2'd0;
    localparam logic [1:0] c_CODE_IND   = 2'd1;
    localparam logic [1:0] c_CODE_WRITE = 2'd2;
    localparam logic [1:0] c_CODE_IDLE  = 2'd3;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [15:0] r_din, w_din_nxt;
    logic [15:0] r_memout, w_memout_nxt;
    logic [15:0] r_ptr, w_ptr_nxt;
    logic        r_req, w_req_nxt;
    logic        r_we, w_we_nxt;
    logic        r_ind_pending, w_ind_pending_nxt;

`ifdef LC3_MEM_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic        r_err, w_err_nxt;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_addr_nxt        = r_addr;
        w_din_nxt         = r_din;
        w_memout_nxt      = r_memout;
        w_ptr_nxt         = r_ptr;
        w_req_nxt         = r_req;
        w_we_nxt          = r_we;
        w_ind_pending_nxt = r_ind_pending;
`ifdef LC3_MEM_TIMEOUT_EN
        w_wait_cnt_nxt    = r_wait_cnt;
        w_err_nxt         = r_err;
`endif

        case (r_state)
            IDLE: begin
                if (mem_state != c_CODE_IDLE) begin
                    // Second phase of an indirect access goes through the fetched pointer.
                    w_addr_nxt = r_ind_pending ? r_ptr : M_Addr;
                    w_din_nxt  = M_Data;
                    w_req_nxt  = 1'b1;
                    w_we_nxt   = (mem_state == c_CODE_WRITE);
`ifdef LC3_MEM_TIMEOUT_EN
                    w_wait_cnt_nxt = 8'd0;
`endif
                end
                case (mem_state)
                    c_CODE_READ: begin
                        w_state_nxt       = RD_WAIT;
                        w_ind_pending_nxt = 1'b0;
                    end
                    c_CODE_IND: begin
                        w_state_nxt = IND_WAIT;
                    end
                    c_CODE_WRITE: begin
                        w_state_nxt       = WR_WAIT;
                        w_ind_pending_nxt = 1'b0;
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end

            RD_WAIT, IND_WAIT, WR_WAIT: begin
                if (dmem.DMem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_state_nxt = DONE;
                    if (r_state == RD_WAIT) begin
                        w_memout_nxt = dmem.DMem_dout;
                    end
                    if (r_state == IND_WAIT) begin
                        w_ptr_nxt         = dmem.DMem_dout;
                        w_ind_pending_nxt = 1'b1;
                    end
                end
`ifdef LC3_MEM_TIMEOUT_EN
                else if (r_wait_cnt == c_TIMEOUT_LIMIT) begin
                    // Abandon the access but still hand completion back to the controller.
                    w_req_nxt         = 1'b0;
                    w_we_nxt          = 1'b0;
                    w_err_nxt         = 1'b1;
                    w_ind_pending_nxt = 1'b0;
                    w_state_nxt       = DONE;
                end
                else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
`endif
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_addr        <= 16'h0000;
            r_din         <= 16'h0000;
            r_memout      <= 16'h0000;
            r_ptr         <= 16'h0000;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_ind_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_din         <= w_din_nxt;
            r_memout      <= w_memout_nxt;
            r_ptr         <= w_ptr_nxt;
            r_req         <= w_req_nxt;
            r_we          <= w_we_nxt;
            r_ind_pending <= w_ind_pending_nxt;
        end
    end

`ifdef LC3_MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign mem_err = r_err;
`else
    // Constant 0 for any legal TIMEOUT_CYCLES (1..255); no watchdog in this build.
    assign mem_err = (TIMEOUT_CYCLES == 0);
`endif

    assign dmem.DMem_addr = r_addr;
    assign dmem.DMem_din  = r_din;
    assign dmem.DMem_req  = r_req;
    assign dmem.DMem_we   = r_we;
    assign memout         = r_memout;
    assign complete_data  = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_lc3_memaccess.sv
//==============================================================================
// Module   : tb_lc3_memaccess
// Desc     : Self-checking bench for lc3_memaccess with a variable-latency
//            memory responder and an expected-transaction scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lc3_memaccess;

    localparam int c_TIMEOUT     = 4;
    localparam int c_PHASE_LIMIT = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_state;
    logic [15:0] M_Addr;
    logic [15:0] M_Data;
    logic [15:0] memout;
    logic        complete_data;
    logic        mem_err;

    lc3_memaccess_if dmem_if ();

    lc3_memaccess #(
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_state     (mem_state),
        .M_Addr        (M_Addr),
        .M_Data        (M_Data),
        .dmem          (dmem_if),
        .memout        (memout),
        .complete_data (complete_data),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    int          n_checks   = 0;
    int          n_fails    = 0;
    int          n_complete = 0;
    int          ack_delay  = 0;
    bit          stray      = 1'b0;
    logic [32:0] exp_q[$];                 // {we, addr, din}
    logic [15:0] mem [logic [15:0]];
    logic [15:0] mo_m  = 16'h0000;
    logic [15:0] ptr_m = 16'h0000;
    bit          ind_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // Memory responder: acks after ack_delay cycles, checks each request cycle against the scoreboard head.
    initial begin
        int wcnt;
        int rcnt;
        wcnt = 0;
        rcnt = 0;
        dmem_if.DMem_ack  = 1'b0;
        dmem_if.DMem_dout = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                dmem_if.DMem_ack = 1'b0;
                wcnt = 0;
                rcnt = 0;
            end else if (dmem_if.DMem_ack) begin
                dmem_if.DMem_ack = 1'b0;
            end else if (stray) begin
                dmem_if.DMem_dout = 16'hDEAD;
                dmem_if.DMem_ack  = 1'b1;
                stray = 1'b0;
            end else if (dmem_if.DMem_req) begin
                rcnt++;
                if (exp_q.size() == 0) begin
                    chk("txn_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("txn", 64'({dmem_if.DMem_we, dmem_if.DMem_addr, dmem_if.DMem_din}), 64'(exp_q[0]));
                end
                if (wcnt >= ack_delay) begin
                    chk("req_len", 64'(rcnt), 64'(ack_delay + 1));
                    if (dmem_if.DMem_we) mem[dmem_if.DMem_addr] = dmem_if.DMem_din;
                    else                 dmem_if.DMem_dout = rd(dmem_if.DMem_addr);
                    dmem_if.DMem_ack = 1'b1;
                    wcnt = 0;
                    rcnt = 0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                rcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (complete_data === 1'b1) n_complete++;
        end
    end

    // One access phase; called and returns at posedge+1.
    task automatic run_phase(input logic [1:0] code, input logic [15:0] a, input logic [15:0] d, input int dly);
        int          cycles;
        int          cd0;
        logic [15:0] ea;
        logic [15:0] rv;
        ea  = ind_m ? ptr_m : a;
        rv  = rd(ea);
        cd0 = n_complete;
        ack_delay = dly;
        mem_state = code;
        M_Addr    = a;
        M_Data    = d;
        exp_q.push_back({(code == 2'd2), ea, d});
        @(posedge clk);
        #1;
        mem_state = 2'd3;
        M_Addr    = ~a;
        M_Data    = ~d;
        cycles    = 1;
        while (complete_data !== 1'b1 && cycles < c_PHASE_LIMIT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("phase_latency", 64'(cycles), 64'(dly + 2));
        case (code)
            2'd0:    begin mo_m = rv; ind_m = 1'b0; end
            2'd1:    begin ptr_m = rv; ind_m = 1'b1; end
            default: begin ind_m = 1'b0; end
        endcase
        chk("memout", 64'(memout), 64'(mo_m));
        chk("req_after_ack", 64'(dmem_if.DMem_req), 64'd0);
        @(posedge clk);
        #1;
        chk("complete_pulses", 64'(n_complete - cd0), 64'd1);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int cd0;
        rst       = 1'b0;
        mem_state = 2'd3;
        M_Addr    = 16'h0000;
        M_Data    = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",      64'(dmem_if.DMem_req),  64'd0);
        chk("rst_we",       64'(dmem_if.DMem_we),   64'd0);
        chk("rst_addr",     64'(dmem_if.DMem_addr), 64'd0);
        chk("rst_din",      64'(dmem_if.DMem_din),  64'd0);
        chk("rst_memout",   64'(memout),            64'd0);
        chk("rst_complete", 64'(complete_data),     64'd0);
        chk("rst_err",      64'(mem_err),           64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Plain zero-wait load
        mem[16'h3000] = 16'h1234;
        run_phase(2'd0, 16'h3000, 16'h0000, 0);
        chk("load_memout", 64'(memout), 64'h1234);

        // Store with 5-cycle ack delay
        run_phase(2'd2, 16'h4000, 16'hBEEF, 5);
        chk("store_mem", 64'(rd(16'h4000)), 64'hBEEF);
        chk("store_memout_kept", 64'(memout), 64'h1234);

        // Indirect load
        mem[16'h3000] = 16'h5000;
        mem[16'h5000] = 16'hCAFE;
        cd0 = n_complete;
        run_phase(2'd1, 16'h3000, 16'h0000, 0);
        chk("ind_ptr_memout_kept", 64'(memout), 64'h1234);
        run_phase(2'd0, 16'h3000, 16'h0000, 2);
        chk("ind_load_memout", 64'(memout), 64'hCAFE);
        chk("ind_load_pulses", 64'(n_complete - cd0), 64'd2);

        // Indirect store, then a plain read must use M_Addr again
        mem[16'h3000] = 16'h6000;
        run_phase(2'd1, 16'h3000, 16'h00AA, 1);
        run_phase(2'd2, 16'h3000, 16'h00AA, 0);
        chk("ind_store_mem", 64'(rd(16'h6000)), 64'h00AA);
        run_phase(2'd0, 16'h3000, 16'h0000, 0);
        chk("ind_cleared_memout", 64'(memout), 64'h6000);

        // Stray ack in IDLE
        cd0   = n_complete;
        stray = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stray_memout",   64'(memout),               64'h6000);
        chk("stray_req",      64'(dmem_if.DMem_req),     64'd0);
        chk("stray_addr",     64'(dmem_if.DMem_addr),    64'h3000);
        chk("stray_complete", 64'(n_complete - cd0),     64'd0);

        // Reset in the middle of RD_WAIT with an indirect pointer pending
        mem[16'h3000] = 16'h7000;
        run_phase(2'd1, 16'h3000, 16'h0000, 0);
        cd0       = n_complete;
        ack_delay = 100;
        mem_state = 2'd0;
        M_Addr    = 16'h1111;
        M_Data    = 16'h2222;
        exp_q.push_back({1'b0, ptr_m, 16'h2222});
        @(posedge clk);
        #1;
        mem_state = 2'd3;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_req",      64'(dmem_if.DMem_req),  64'd0);
        chk("midrst_we",       64'(dmem_if.DMem_we),   64'd0);
        chk("midrst_addr",     64'(dmem_if.DMem_addr), 64'd0);
        chk("midrst_din",      64'(dmem_if.DMem_din),  64'd0);
        chk("midrst_memout",   64'(memout),            64'd0);
        chk("midrst_complete", 64'(complete_data),     64'd0);
        exp_q.delete();
        mo_m  = 16'h0000;
        ptr_m = 16'h0000;
        ind_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_pulse", 64'(n_complete - cd0), 64'd0);
        mem[16'h3000] = 16'h4321;
        run_phase(2'd0, 16'h3000, 16'h0000, 1);
        chk("after_rst_memout", 64'(memout), 64'h4321);

`ifdef LC3_MEM_TIMEOUT_EN
        begin
            int cycles;
            cd0       = n_complete;
            ack_delay = 1000;
            mem_state = 2'd0;
            M_Addr    = 16'h2000;
            M_Data    = 16'h0000;
            exp_q.push_back({1'b0, 16'h2000, 16'h0000});
            @(posedge clk);
            #1;
            mem_state = 2'd3;
            cycles    = 1;
            while (complete_data !== 1'b1 && cycles < c_PHASE_LIMIT) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            chk("to_latency", 64'(cycles), 64'(c_TIMEOUT + 2));
            chk("to_req",     64'(dmem_if.DMem_req), 64'd0);
            chk("to_err",     64'(mem_err),          64'd1);
            chk("to_memout",  64'(memout),           64'(mo_m));
            exp_q.delete();
            @(posedge clk);
            #1;
            chk("to_pulses", 64'(n_complete - cd0), 64'd1);
            run_phase(2'd0, 16'h3000, 16'h0000, 0);
            chk("to_err_sticky", 64'(mem_err), 64'd1);
        end
`else
        cd0       = n_complete;
        ack_delay = 1000;
        mem_state = 2'd0;
        M_Addr    = 16'h2000;
        M_Data    = 16'h0000;
        exp_q.push_back({1'b0, 16'h2000, 16'h0000});
        @(posedge clk);
        #1;
        mem_state = 2'd3;
        repeat (300) @(posedge clk);
        #1;
        chk("noto_req_held", 64'(dmem_if.DMem_req),  64'd1);
        chk("noto_err",      64'(mem_err),           64'd0);
        chk("noto_no_pulse", 64'(n_complete - cd0),  64'd0);
        rst = 1'b0;
        #1;
        exp_q.delete();
        mo_m  = 16'h0000;
        ind_m = 1'b0;
        chk("noto_rst_req", 64'(dmem_if.DMem_req), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_phase(2'd0, 16'h3000, 16'h0000, 0);
        chk("noto_final_err", 64'(mem_err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
